// File: rtl/cdce_cfg_pkg.sv
// ============================================================================
// Module   : cdce_cfg_pkg
// Purpose  : Shared state encoding and error codes for the CDCE config sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cdce_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PD_HOLD,
        ST_WRITE,
        ST_GAP,
        ST_RDBK,
        ST_WAIT_LOCK,
        ST_NEXT_DEV,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LOCK = 2'd1;
    localparam logic [1:0] ERR_RDBK = 2'd2;
    localparam logic [1:0] ERR_PWR  = 2'd3;

    localparam logic [3:0] RD_INSTR = 4'hE;

endpackage

`default_nettype wire

// File: rtl/cdce_spi_shift.sv
// ============================================================================
// Module   : cdce_spi_shift
// Purpose  : 32-bit LSB-first SPI frame engine, CS low for 65*CLK_DIV cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdce_spi_shift #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi,
    output logic [31:0] rx_word,
    output logic        done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_active;
    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_half;
    logic [31:0]      r_shift;

    // Half-period 2k raises SCK (and samples MISO), 2k+1 lowers it; half 64 ends the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_half   <= '0;
            r_shift  <= '0;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            rx_word  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_active <= 1'b0;
                cs_n     <= 1'b1;
                sck      <= 1'b0;
                mosi     <= 1'b0;
            end else if (!r_active) begin
                if (start) begin
                    r_active <= 1'b1;
                    cs_n     <= 1'b0;
                    r_shift  <= tx_word;
                    mosi     <= tx_word[0];
                    r_div    <= '0;
                    r_half   <= '0;
                end
            end else if (r_div != DIV_LAST) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
                if (r_half == 7'd64) begin
                    r_active <= 1'b0;
                    cs_n     <= 1'b1;
                    mosi     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    r_half <= r_half + 7'd1;
                    if (!r_half[0]) begin
                        sck     <= 1'b1;
                        rx_word <= {miso, rx_word[31:1]};
                    end else begin
                        sck     <= 1'b0;
                        r_shift <= {1'b0, r_shift[31:1]};
                        mosi    <= r_shift[1];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdce_cfg_sched.sv
// ============================================================================
// Module   : cdce_cfg_sched
// Purpose  : Configures CLOCK2 then CLOCK3 over one shared SPI engine and waits
//            for PLL lock. Optional readback is enabled by CFG_READBACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdce_cfg_sched
    import cdce_cfg_pkg::*;
#(
    parameter int NUM_WORDS    = 9,
    parameter int CLK_DIV      = 4,
    parameter int PD_CYCLES    = 4800,
    parameter int LOCK_TIMEOUT = 480000,
    parameter int RETRY_MAX    = 3
) (
    input  logic        main_48mhz_clk_r_i,
    input  logic        fpga_rstn,
    input  logic        start_i,
    input  logic        pwr_good_i,
    output logic        word_dev_o,
    output logic [3:0]  word_addr_o,
    input  logic [31:0] word_data_i,
    output logic        clock2_sspcs1_o,
    output logic        clock3_sspcs1_o,
    output logic        clock2_sspck_o,
    output logic        clock3_sspck_o,
    output logic        clock2_sspsi_o,
    output logic        clock3_sspsi_o,
    input  logic        clock2_sspso_i,
    input  logic        clock3_sspso_i,
    output logic        refclk2_pd_no,
    output logic        refclk3_pd_no,
    input  logic        clock2_pll_lock_i,
    input  logic        clock3_pll_lock_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        err_dev_o
);

    state_t      r_state;
    logic        r_dev;
    logic [3:0]  r_addr;
    logic [31:0] r_cnt;
    logic [7:0]  r_attempt;
    logic [1:0]  r_pd_n;
    logic        r_busy;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic        r_err_dev;
    logic        r_spi_start;
    logic [1:0]  r_lock_meta;
    logic [1:0]  r_lock_sync;

    logic        w_abort;
    logic        w_lock_sel;
    logic        w_miso;
    logic [31:0] w_tx_word;
    logic        w_cs_n;
    logic        w_sck;
    logic        w_mosi;
    logic [31:0] w_rx_word;
    logic        w_spi_done;

`ifdef CFG_READBACK_EN
    logic r_rdbk;
    logic r_rd_resp;

    assign w_tx_word = (r_state != ST_RDBK) ? word_data_i :
                       r_rd_resp            ? 32'd0 : {24'd0, r_addr, RD_INSTR};
`else
    logic w_unused_rx;

    assign w_tx_word   = word_data_i;
    assign w_unused_rx = ^w_rx_word;
`endif

    assign w_abort    = r_busy & ~pwr_good_i;
    assign w_lock_sel = r_dev ? r_lock_sync[1] : r_lock_sync[0];
    assign w_miso     = r_dev ? clock3_sspso_i : clock2_sspso_i;

    cdce_spi_shift #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk     (main_48mhz_clk_r_i),
        .rst_n   (fpga_rstn),
        .start   (r_spi_start),
        .abort   (w_abort),
        .tx_word (w_tx_word),
        .miso    (w_miso),
        .cs_n    (w_cs_n),
        .sck     (w_sck),
        .mosi    (w_mosi),
        .rx_word (w_rx_word),
        .done    (w_spi_done)
    );

    // The engine idles with CS high and SCK/SI low, so switching r_dev between frames is glitch-free.
    assign clock2_sspcs1_o = r_dev ? 1'b1 : w_cs_n;
    assign clock3_sspcs1_o = r_dev ? w_cs_n : 1'b1;
    assign clock2_sspck_o  = r_dev ? 1'b0 : w_sck;
    assign clock3_sspck_o  = r_dev ? w_sck : 1'b0;
    assign clock2_sspsi_o  = r_dev ? 1'b0 : w_mosi;
    assign clock3_sspsi_o  = r_dev ? w_mosi : 1'b0;

    assign refclk2_pd_no = r_pd_n[0];
    assign refclk3_pd_no = r_pd_n[1];
    assign word_dev_o    = r_dev;
    assign word_addr_o   = r_addr;
    assign busy_o        = r_busy;
    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign err_dev_o     = r_err_dev;
    assign done_o        = (r_state == ST_DONE) & r_lock_sync[0] & r_lock_sync[1];

    always_ff @(posedge main_48mhz_clk_r_i or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            r_state     <= ST_IDLE;
            r_dev       <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_attempt   <= '0;
            r_pd_n      <= 2'b00;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_dev   <= 1'b0;
            r_spi_start <= 1'b0;
            r_lock_meta <= 2'b00;
            r_lock_sync <= 2'b00;
`ifdef CFG_READBACK_EN
            r_rdbk      <= 1'b0;
            r_rd_resp   <= 1'b0;
`endif
        end else begin
            r_lock_meta <= {clock3_pll_lock_i, clock2_pll_lock_i};
            r_lock_sync <= r_lock_meta;
            r_spi_start <= 1'b0;
            if (w_abort) begin
                r_state    <= ST_ERROR;
                r_busy     <= 1'b0;
                r_err      <= 1'b1;
                r_err_code <= ERR_PWR;
                r_err_dev  <= r_dev;
                r_pd_n     <= 2'b00;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start_i && pwr_good_i) begin
                            r_state    <= ST_PD_HOLD;
                            r_dev      <= 1'b0;
                            r_addr     <= '0;
                            r_cnt      <= '0;
                            r_attempt  <= '0;
                            r_pd_n[0]  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                            r_err_code <= ERR_NONE;
                            r_err_dev  <= 1'b0;
                        end
                    end
                    ST_PD_HOLD: begin
                        if (r_cnt == 32'(PD_CYCLES - 1)) begin
                            r_pd_n[r_dev] <= 1'b1;
                            r_addr        <= '0;
                            r_cnt         <= '0;
                            r_spi_start   <= 1'b1;
                            r_state       <= ST_WRITE;
`ifdef CFG_READBACK_EN
                            r_rdbk        <= 1'b0;
                            r_rd_resp     <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    ST_WRITE: begin
                        if (w_spi_done) begin
                            r_cnt   <= '0;
                            r_state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // Exit one cycle early: the engine drops CS one cycle after r_spi_start.
                        if (r_cnt == 32'(2 * CLK_DIV - 2)) begin
                            r_cnt <= '0;
`ifdef CFG_READBACK_EN
                            if (r_rdbk) begin
                                r_state     <= ST_RDBK;
                                r_spi_start <= 1'b1;
                            end else
`endif
                            if (r_addr != 4'(NUM_WORDS - 1)) begin
                                r_addr      <= r_addr + 4'd1;
                                r_spi_start <= 1'b1;
                                r_state     <= ST_WRITE;
                            end else begin
`ifdef CFG_READBACK_EN
                                r_rdbk      <= 1'b1;
                                r_rd_resp   <= 1'b0;
                                r_addr      <= '0;
                                r_spi_start <= 1'b1;
                                r_state     <= ST_RDBK;
`else
                                r_state     <= ST_WAIT_LOCK;
`endif
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
`ifdef CFG_READBACK_EN
                    ST_RDBK: begin
                        if (w_spi_done) begin
                            r_cnt <= '0;
                            if (!r_rd_resp) begin
                                r_rd_resp <= 1'b1;
                                r_state   <= ST_GAP;
                            end else if (w_rx_word[31:4] != word_data_i[31:4]) begin
                                r_state    <= ST_ERROR;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= ERR_RDBK;
                                r_err_dev  <= r_dev;
                            end else if (r_addr == 4'(NUM_WORDS - 1)) begin
                                r_state <= ST_WAIT_LOCK;
                            end else begin
                                r_addr    <= r_addr + 4'd1;
                                r_rd_resp <= 1'b0;
                                r_state   <= ST_GAP;
                            end
                        end
                    end
`endif
                    ST_WAIT_LOCK: begin
                        if (w_lock_sel) begin
                            r_state <= ST_NEXT_DEV;
                        end else if (r_cnt == 32'(LOCK_TIMEOUT - 1)) begin
                            if (r_attempt == 8'(RETRY_MAX - 1)) begin
                                r_state    <= ST_ERROR;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= ERR_LOCK;
                                r_err_dev  <= r_dev;
                            end else begin
                                r_attempt     <= r_attempt + 8'd1;
                                r_pd_n[r_dev] <= 1'b0;
                                r_cnt         <= '0;
                                r_state       <= ST_PD_HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    ST_NEXT_DEV: begin
                        if (!r_dev) begin
                            r_dev     <= 1'b1;
                            r_addr    <= '0;
                            r_attempt <= '0;
                            r_cnt     <= '0;
                            r_pd_n[1] <= 1'b0;
                            r_state   <= ST_PD_HOLD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cdce_cfg_sched.sv
// ============================================================================
// Module   : tb_cdce_cfg_sched
// Purpose  : Directed bench for cdce_cfg_sched with per-device SPI monitors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdce_cfg_sched;

    localparam int CLK_DIV      = 2;
    localparam int NUM_WORDS    = 2;
    localparam int PD_CYCLES    = 8;
    localparam int LOCK_TIMEOUT = 100;
    localparam int RETRY_MAX    = 2;
`ifdef CFG_READBACK_EN
    localparam int FRAMES_PER_DEV = 3 * NUM_WORDS;
`else
    localparam int FRAMES_PER_DEV = NUM_WORDS;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        pwr_good = 1'b0;
    logic        lock2    = 1'b0;
    logic        lock3    = 1'b0;
    logic        corrupt  = 1'b0;
    logic        word_dev;
    logic [3:0]  word_addr;
    logic [31:0] word_data;
    logic        cs2, cs3, sck2, sck3, si2, si3, so2, so3, pd2, pd3;
    logic        busy, done, err, err_dev;
    logic [1:0]  err_code;
    logic [1:0]  cs, sck, si, pd;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    function automatic logic [31:0] tbl_word(input logic d, input logic [3:0] a);
        case ({d, a})
            5'h00:   return 32'hA5A5_0001;
            5'h01:   return 32'h1234_5678;
            5'h10:   return 32'hCAFE_0F0F;
            5'h11:   return 32'h0BAD_F00D;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign word_data = tbl_word(word_dev, word_addr);
    assign cs  = {cs3, cs2};
    assign sck = {sck3, sck2};
    assign si  = {si3, si2};
    assign pd  = {pd3, pd2};

    // Per-device monitor: decodes frames, times CS low, answers readback instructions.
    for (genvar d = 0; d < 2; d++) begin : g_mon
        logic        prev_cs  = 1'b1;
        logic        prev_sck = 1'b0;
        logic        prev_pd  = 1'b0;
        logic        arm      = 1'b0;
        logic [31:0] sh       = '0;
        logic [31:0] resp     = '0;
        int          lowcnt   = 0;
        int          bits     = 0;
        int          nfr      = 0;
        int          pd_falls = 0;
        logic [31:0] frames [64];
        int          lens   [64];
        logic        so;

        assign so = (arm && bits < 32) ? resp[bits[4:0]] : 1'b0;

        always @(negedge clk) begin
            prev_cs  <= cs[d];
            prev_sck <= sck[d];
            prev_pd  <= pd[d];
            if (prev_pd && !pd[d]) pd_falls <= pd_falls + 1;
            if (!cs[d]) begin
                if (prev_cs) begin
                    lowcnt <= 1;
                    bits   <= 0;
                    sh     <= '0;
                end else begin
                    lowcnt <= lowcnt + 1;
                    if (sck[d] && !prev_sck) begin
                        sh   <= {si[d], sh[31:1]};
                        bits <= bits + 1;
                    end
                end
            end else if (!prev_cs) begin
                frames[nfr % 64] <= sh;
                lens[nfr % 64]   <= lowcnt;
                nfr              <= nfr + 1;
                if (sh[31:8] == 24'd0 && sh[3:0] == 4'hE) begin
                    arm  <= 1'b1;
                    resp <= tbl_word(1'(d), sh[7:4]) ^
                            ((corrupt && sh[7:4] == 4'd1) ? 32'h0000_0100 : 32'h0);
                end else begin
                    arm <= 1'b0;
                end
            end
        end
    end

    assign so2 = g_mon[0].so;
    assign so3 = g_mon[1].so;

    cdce_cfg_sched #(
        .NUM_WORDS    (NUM_WORDS),
        .CLK_DIV      (CLK_DIV),
        .PD_CYCLES    (PD_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RETRY_MAX    (RETRY_MAX)
    ) dut (
        .main_48mhz_clk_r_i (clk),
        .fpga_rstn          (rst_n),
        .start_i            (start),
        .pwr_good_i         (pwr_good),
        .word_dev_o         (word_dev),
        .word_addr_o        (word_addr),
        .word_data_i        (word_data),
        .clock2_sspcs1_o    (cs2),
        .clock3_sspcs1_o    (cs3),
        .clock2_sspck_o     (sck2),
        .clock3_sspck_o     (sck3),
        .clock2_sspsi_o     (si2),
        .clock3_sspsi_o     (si3),
        .clock2_sspso_i     (so2),
        .clock3_sspso_i     (so3),
        .refclk2_pd_no      (pd2),
        .refclk3_pd_no      (pd3),
        .clock2_pll_lock_i  (lock2),
        .clock3_pll_lock_i  (lock3),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err),
        .err_code_o         (err_code),
        .err_dev_o          (err_dev)
    );

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        pwr_good = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (cs2 !== 1'b1)      begin errors++; $display("FAIL reset_cs2 got=%b exp=1", cs2); end
        checks++; if (cs3 !== 1'b1)      begin errors++; $display("FAIL reset_cs3 got=%b exp=1", cs3); end
        checks++; if (sck !== 2'b00)     begin errors++; $display("FAIL reset_sck got=%b exp=00", sck); end
        checks++; if (si !== 2'b00)      begin errors++; $display("FAIL reset_si got=%b exp=00", si); end
        checks++; if (pd !== 2'b00)      begin errors++; $display("FAIL reset_pd got=%b exp=00", pd); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
        checks++; if (err_dev !== 1'b0)  begin errors++; $display("FAIL reset_err_dev got=%b exp=0", err_dev); end
        checks++; if (word_dev !== 1'b0 || word_addr !== 4'd0)
            begin errors++; $display("FAIL reset_word_sel got=%b/%0d exp=0/0", word_dev, word_addr); end
    endtask

    task automatic test_normal();
        int b0, b1, cyc;
        lock2 = 1'b1;
        lock3 = 1'b1;
        repeat (4) @(posedge clk);
        b0 = g_mon[0].nfr;
        b1 = g_mon[1].nfr;
        pulse_start();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy_start got=%b exp=1", busy); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL normal_done got=%b exp=1 (timeout)", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_end got=%b exp=0", busy); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL normal_err got=%b exp=0", err); end
        checks++; if (g_mon[0].nfr - b0 != FRAMES_PER_DEV)
            begin errors++; $display("FAIL normal_frames2 got=%0d exp=%0d", g_mon[0].nfr - b0, FRAMES_PER_DEV); end
        checks++; if (g_mon[0].frames[b0 % 64] !== 32'hA5A5_0001)
            begin errors++; $display("FAIL normal_word0 got=%h exp=a5a50001", g_mon[0].frames[b0 % 64]); end
        checks++; if (g_mon[0].lens[b0 % 64] != 65 * CLK_DIV)
            begin errors++; $display("FAIL normal_cs_len got=%0d exp=%0d", g_mon[0].lens[b0 % 64], 65 * CLK_DIV); end
        checks++; if (g_mon[0].frames[(b0 + 1) % 64] !== 32'h1234_5678)
            begin errors++; $display("FAIL normal_word1 got=%h exp=12345678", g_mon[0].frames[(b0 + 1) % 64]); end
        checks++; if (g_mon[1].nfr - b1 != FRAMES_PER_DEV)
            begin errors++; $display("FAIL normal_frames3 got=%0d exp=%0d", g_mon[1].nfr - b1, FRAMES_PER_DEV); end
        checks++; if (g_mon[1].frames[b1 % 64] !== 32'hCAFE_0F0F)
            begin errors++; $display("FAIL normal_c3_word0 got=%h exp=cafe0f0f", g_mon[1].frames[b1 % 64]); end
        checks++; if (g_mon[1].frames[(b1 + 1) % 64] !== 32'h0BAD_F00D)
            begin errors++; $display("FAIL normal_c3_word1 got=%h exp=0badf00d", g_mon[1].frames[(b1 + 1) % 64]); end
        checks++; if (pd !== 2'b11) begin errors++; $display("FAIL normal_pd got=%b exp=11", pd); end
    endtask

    task automatic test_lock_timeout();
        int f2, f3, cyc;
        lock3 = 1'b0;
        repeat (4) @(posedge clk);
        f2 = g_mon[0].pd_falls;
        f3 = g_mon[1].pd_falls;
        pulse_start();
        cyc = 0;
        while (err !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL lock_err got=%b exp=1 (timeout)", err); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL lock_err_code got=%0d exp=1", err_code); end
        checks++; if (err_dev !== 1'b1)  begin errors++; $display("FAIL lock_err_dev got=%b exp=1", err_dev); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL lock_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL lock_busy got=%b exp=0", busy); end
        checks++; if (g_mon[1].pd_falls - f3 != RETRY_MAX)
            begin errors++; $display("FAIL lock_pd3_holds got=%0d exp=%0d", g_mon[1].pd_falls - f3, RETRY_MAX); end
        checks++; if (g_mon[0].pd_falls - f2 != 1)
            begin errors++; $display("FAIL lock_pd2_holds got=%0d exp=1", g_mon[0].pd_falls - f2); end
    endtask

    task automatic test_pwr_abort();
        int cyc;
        lock3 = 1'b1;
        repeat (4) @(posedge clk);
        pulse_start();
        cyc = 0;
        while (!(cs2 === 1'b0 && g_mon[0].bits >= 4) && cyc < 2000) begin @(negedge clk); cyc++; end
        checks++; if (cyc >= 2000) begin errors++; $display("FAIL abort_frame_wait got=timeout exp=frame"); end
        pwr_good = 1'b0;
        @(negedge clk);
        checks++; if (cs2 !== 1'b1 || cs3 !== 1'b1)
            begin errors++; $display("FAIL abort_cs got=%b%b exp=11", cs3, cs2); end
        checks++; if (sck !== 2'b00)     begin errors++; $display("FAIL abort_sck got=%b exp=00", sck); end
        checks++; if (pd !== 2'b00)      begin errors++; $display("FAIL abort_pd got=%b exp=00", pd); end
        checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL abort_err_code got=%0d exp=3", err_code); end
        checks++; if (err !== 1'b1 || err_dev !== 1'b0)
            begin errors++; $display("FAIL abort_err got=%b/%b exp=1/0", err, err_dev); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        pwr_good = 1'b1;
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_recover_done got=%b exp=1", done); end
        checks++; if (err !== 1'b0 || err_code !== 2'd0)
            begin errors++; $display("FAIL abort_recover_err got=%b/%0d exp=0/0", err, err_code); end
    endtask

    task automatic test_lock_drop();
        bit fell;
        fell = 1'b0;
        @(negedge clk);
        lock2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b0) fell = 1'b1;
        end
        checks++; if (!fell)       begin errors++; $display("FAIL drop_done got=%b exp=0 within 3", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_err got=%b exp=0", err); end
        lock2 = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_relock_done got=%b exp=1", done); end
    endtask

`ifdef CFG_READBACK_EN
    task automatic test_readback_mismatch();
        int f2, cyc;
        corrupt = 1'b1;
        f2 = g_mon[0].pd_falls;
        pulse_start();
        cyc = 0;
        while (err !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        repeat (4 * LOCK_TIMEOUT) @(negedge clk);
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL rdbk_err_code got=%0d exp=2", err_code); end
        checks++; if (err_dev !== 1'b0)  begin errors++; $display("FAIL rdbk_err_dev got=%b exp=0", err_dev); end
        checks++; if (g_mon[0].pd_falls - f2 != 1)
            begin errors++; $display("FAIL rdbk_no_retry got=%0d exp=1", g_mon[0].pd_falls - f2); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rdbk_done got=%b exp=0", done); end
        corrupt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_lock_timeout();
        test_pwr_abort();
        test_lock_drop();
`ifdef CFG_READBACK_EN
        test_readback_mismatch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdce_cfg_sched.md
# cdce_cfg_sched

Sequencer that configures both on-board CDCE clock synthesizers (CLOCK2, CLOCK3) after power-good, then reports PLL lock. It is a single scheduler that owns one SPI shift engine, which serves both devices in turn: CLOCK2 first, then CLOCK3. For each device it handles power-down release, the register word writes, optional readback, and the lock wait with retries. The block sits in shevm_fpga_core beside the power sequencer and drives the CLOCK2_*/CLOCK3_* and REFCLKx_PD_np pins. Register contents come from an external lookup table.

## Interface
Parameters:
- NUM_WORDS, 9: register words written per device (1..16).
- CLK_DIV, 4: SPI half-period in clock cycles (>=1). The default gives 6 MHz SCK.
- PD_CYCLES, 4800: refclk_pd_no low hold before release, 100 us.
- LOCK_TIMEOUT, 480000: cycles to wait for PLL lock per attempt, 10 ms.
- RETRY_MAX, 3: total lock attempts per device.

Ports (one clock; reset is asynchronous and active-low):
- main_48mhz_clk_r_i  in  1  system clock, 48 MHz.
- fpga_rstn  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle request to (re)configure both devices.
- pwr_good_i  in  1  rails good; low aborts the sequence.
- word_dev_o  out  1  table select, 0=CLOCK2, 1=CLOCK3.
- word_addr_o  out  4  table index.
- word_data_i  in  32  table word, combinational from {word_dev_o, word_addr_o}.
- clock2_sspcs1_o / clock3_sspcs1_o  out  1  chip selects, active-low.
- clock2_sspck_o / clock3_sspck_o  out  1  SPI clock.
- clock2_sspsi_o / clock3_sspsi_o  out  1  serial data to the device.
- clock2_sspso_i / clock3_sspso_i  in  1  serial data from the device.
- refclk2_pd_no / refclk3_pd_no  out  1  device power-down, active-low.
- clock2_pll_lock_i / clock3_pll_lock_i  in  1  asynchronous lock inputs.
- busy_o  out  1  sequence in progress.
- done_o  out  1  both devices configured and locked.
- err_o  out  1  sticky failure flag.
- err_code_o  out  2  failure cause: 0 none, 1 lock timeout, 2 readback mismatch, 3 power abort.
- err_dev_o  out  1  device that failed.

## Operation
States are IDLE, PD_HOLD, WRITE, GAP, RDBK, WAIT_LOCK, NEXT_DEV, DONE and ERROR.
- IDLE: when start_i=1 and pwr_good_i=1, select device 0, clear err_o/err_code_o/err_dev_o, and go to PD_HOLD.
- PD_HOLD: drive the selected device's refclk_pd_no low for PD_CYCLES, release it to 1, then go to WRITE with word index 0.
- WRITE: send one 32-bit frame of word_data_i, LSB first, then go to GAP.
- GAP: after the gap time, move on to the next word. After word NUM_WORDS-1, go to RDBK if readback is compiled in, otherwise to WAIT_LOCK.
- WAIT_LOCK: on synchronized lock=1, go to NEXT_DEV.
  - On timeout with attempts remaining, return to PD_HOLD for the same device.
  - On timeout with RETRY_MAX attempts used, go to ERROR with code 1.
- NEXT_DEV: after device 0, select device 1 and go to PD_HOLD. After device 1, go to DONE.
- DONE: done_o=1 while both synchronized locks are 1. If a lock drops, done_o falls the same cycle; the state stays DONE.
  - start_i in DONE or ERROR restarts from device 0.
  - start_i while busy is ignored.
- Power abort: pwr_good_i=0 in any busy state goes to ERROR with code 3 on the next cycle. All chip selects go high, SCK goes low and both refclk_pd_no go low.
- Idle pins: the unselected device's CS stays high and its SCK/SI stay low.

## Timing
- Reset values:
  - All sspcs 1; all sspck and sspsi 0.
  - Both refclk_pd_no 0.
  - busy_o, done_o and err_o 0; err_code_o 0; err_dev_o 0.
  - word_dev_o and word_addr_o 0.
- Frame sequence:
  - CS falls with bit 0 already on SI.
  - After CLK_DIV cycles, SCK rises; the device samples on this edge.
  - SCK falls CLK_DIV cycles later and SI advances to the next bit.
  - This repeats for 32 rising edges.
  - CS rises CLK_DIV cycles after the last falling edge.
- CS is low for exactly 65*CLK_DIV cycles. GAP holds CS high for 2*CLK_DIV cycles.
- word_data_i is captured into the shift register on the cycle CS falls.
- Lock inputs pass through a 2-flop synchronizer. The LOCK_TIMEOUT counter starts on the cycle WAIT_LOCK is entered.
- busy_o is 1 from the cycle after start_i is accepted until DONE or ERROR is entered.

## Configuration
- CFG_READBACK_EN defined: after each device's writes, RDBK runs for each index k in turn.
  - It sends the instruction frame {24'd0, k[3:0], 4'hE}, waits GAP, then clocks a 32-bit response frame.
  - The response is sampled from sspso on SCK rising edges, LSB first.
  - Response bits [31:4] are compared with the table word bits [31:4].
  - A mismatch goes to ERROR with code 2 and no retry.
- CFG_READBACK_EN undefined: there is no RDBK state; sspso inputs are unused and code 2 never occurs.

## Structure
- Package cdce_cfg_pkg holds the state enum, the err_code localparams (ERR_NONE, ERR_LOCK, ERR_RDBK, ERR_PWR) and the 4'hE read-instruction constant.
- Sub-module cdce_spi_shift is the single 32-bit frame engine:
  - Inputs: start, CLK_DIV, tx word, miso.
  - Outputs: cs_n, sck, mosi, rx word, done pulse.
- The scheduler muxes the engine's outputs onto the selected device's pins.

## Test plan
Bench parameters: CLK_DIV=2, NUM_WORDS=2, PD_CYCLES=8, LOCK_TIMEOUT=100, RETRY_MAX=2.
- Reset release, no start: all CS 1, SCK 0, pd_no 0, busy_o 0, done_o 0.
- Table word 32'hA5A5_0001 to CLOCK2 with locks tied 1:
  - Bench SPI monitor decodes 32'hA5A5_0001 LSB first.
  - CS low exactly 130 cycles; CLOCK3 is configured next.
  - done_o=1 and busy_o=0.
- CLOCK3 lock held 0: two PD_HOLD cycles on refclk3, then err_o=1, err_code_o=1, err_dev_o=1, done_o=0.
- pwr_good_i forced 0 mid-frame on CLOCK2:
  - Next cycle: CS 1, SCK 0, both pd_no 0, err_code_o=3.
  - A new start_i with pwr_good_i=1 completes normally.
- CFG_READBACK_EN with a model returning word 1 with bit 8 flipped: err_code_o=2, err_dev_o=0, no retry.
- After done_o=1, drop clock2_pll_lock_i: done_o falls within 3 cycles; err_o stays 0.
